// File: rtl/eg_slot_scheduler_pkg.sv
// Shared types and constants for the envelope-memory slot scheduler.
package vm2413;
  localparam int NSLOTS      = 18;
  localparam int SLOT_CYCLES = 4;
  localparam int INIT_CYCLES = 18;

  typedef logic [4:0]  SLOT_TYPE;
  typedef logic [24:0] EGDATA_TYPE;

  // Slot phases: read issue, read data return, EG write-back, host window.
  typedef enum logic [1:0] {
    ST_READ  = 2'd0,
    ST_LATCH = 2'd1,
    ST_EGWR  = 2'd2,
    ST_HOST  = 2'd3
  } STAGE_TYPE;

  localparam SLOT_TYPE LAST_SLOT = SLOT_TYPE'(NSLOTS - 1);

  function automatic logic slot_valid(input SLOT_TYPE s);
    return s <= LAST_SLOT;
  endfunction
endpackage

// File: rtl/eg_slot_scheduler_if.sv
// Memory, envelope-calculator and host signals of the slot scheduler.
interface eg_slot_scheduler_if;
  import vm2413::*;

  SLOT_TYPE   mem_raddr;
  EGDATA_TYPE mem_rdata;
  SLOT_TYPE   mem_waddr;
  logic       mem_wr;
  EGDATA_TYPE mem_wdata;

  SLOT_TYPE   eg_slot;
  EGDATA_TYPE eg_cur;
  logic       eg_cur_vld;
  EGDATA_TYPE eg_next;

  logic       host_req;
  SLOT_TYPE   host_slot;
  EGDATA_TYPE host_data;
  logic       host_ack;

  logic       frame_sync;
  logic       init_busy;

  modport master (
    output mem_raddr, mem_waddr, mem_wr, mem_wdata,
    output eg_slot, eg_cur, eg_cur_vld, host_ack, frame_sync, init_busy,
    input  mem_rdata, eg_next, host_req, host_slot, host_data
  );

  modport slave (
    input  mem_raddr, mem_waddr, mem_wr, mem_wdata,
    input  eg_slot, eg_cur, eg_cur_vld, host_ack, frame_sync, init_busy,
    output mem_rdata, eg_next, host_req, host_slot, host_data
  );
endinterface

// File: rtl/eg_slot_scheduler_counter.sv
// Stage/slot counters with 17->0 wrap; exposes next-cycle position so the
// top can register its outputs against the phase they will be visible in.
module eg_slot_counter
  import vm2413::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_adv,
  input  logic      i_run_next,
  output STAGE_TYPE o_nstage,
  output SLOT_TYPE  o_nslot,
  output logic      o_frame_sync
);
  STAGE_TYPE r_stage;
  SLOT_TYPE  r_slot;
  logic      r_fsync;
  STAGE_TYPE w_nstage;
  SLOT_TYPE  w_nslot;

  always_comb begin
    w_nstage = r_stage;
    w_nslot  = r_slot;
    if (i_adv) begin
      w_nstage = STAGE_TYPE'(r_stage + 2'd1);
      if (r_stage == ST_HOST)
        w_nslot = (r_slot == LAST_SLOT) ? '0 : r_slot + 5'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= ST_READ;
      r_slot  <= '0;
      r_fsync <= 1'b0;
    end else begin
      r_stage <= w_nstage;
      r_slot  <= w_nslot;
      r_fsync <= i_run_next && (w_nstage == ST_READ) && (w_nslot == '0);
    end
  end

  assign o_nstage     = w_nstage;
  assign o_nslot      = w_nslot;
  assign o_frame_sync = r_fsync;
endmodule

// File: rtl/eg_slot_scheduler.sv
// Slot sequencer and write-port arbiter between the envelope calculator,
// the host, and the 18-entry envelope memory.
module eg_slot_scheduler
  import vm2413::*;
(
  input  logic                clk,
  input  logic                reset,
  eg_slot_scheduler_if.master bus
);
  typedef enum logic {PH_INIT, PH_RUN} phase_t;

  phase_t     r_phase;
  logic [4:0] r_init_cnt;
  logic       r_init_busy;
  SLOT_TYPE   r_raddr;
  SLOT_TYPE   r_waddr;
  logic       r_wr;
  logic       r_wsel_host;
  EGDATA_TYPE r_hdata;
  SLOT_TYPE   r_eg_slot;
  EGDATA_TYPE r_eg_cur;
  logic       r_eg_vld;
  logic       r_ack;

  logic       w_run_next;
  STAGE_TYPE  w_nstage;
  SLOT_TYPE   w_nslot;
  logic       w_fsync;

  // The last init clock already loads the first run-phase outputs.
  assign w_run_next = (r_phase == PH_RUN) ||
                      (r_init_cnt == 5'(INIT_CYCLES - 1));

  eg_slot_counter u_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_adv        (r_phase == PH_RUN),
    .i_run_next   (w_run_next),
    .o_nstage     (w_nstage),
    .o_nslot      (w_nslot),
    .o_frame_sync (w_fsync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase     <= PH_INIT;
      r_init_cnt  <= '0;
      r_init_busy <= 1'b1;
      r_raddr     <= '0;
      r_waddr     <= '0;
      r_wr        <= 1'b0;
      r_wsel_host <= 1'b0;
      r_hdata     <= '0;
      r_eg_slot   <= '0;
      r_eg_cur    <= '0;
      r_eg_vld    <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_wr     <= 1'b0;
      r_ack    <= 1'b0;
      r_eg_vld <= 1'b0;

      case (r_phase)
        PH_INIT: begin
          r_init_cnt <= r_init_cnt + 5'd1;
          if (w_run_next) begin
            r_phase     <= PH_RUN;
            r_init_busy <= 1'b0;
          end
        end
        default: ;
      endcase

      if (w_run_next) begin
        case (w_nstage)
          ST_READ: r_raddr <= w_nslot;
          ST_EGWR: begin
            // Read data returned during the latch stage; present and write back.
            r_eg_cur    <= bus.mem_rdata;
            r_eg_slot   <= w_nslot;
            r_eg_vld    <= 1'b1;
            r_wr        <= 1'b1;
            r_waddr     <= w_nslot;
            r_wsel_host <= 1'b0;
          end
          ST_HOST: begin
            if (bus.host_req) begin
              r_ack <= 1'b1;
              if (slot_valid(bus.host_slot)) begin
                r_wr        <= 1'b1;
                r_waddr     <= bus.host_slot;
                r_hdata     <= bus.host_data;
                r_wsel_host <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // eg_next is sampled by the memory on the EG write clock itself.
  assign bus.mem_wdata  = !r_wr ? '0 : (r_wsel_host ? r_hdata : bus.eg_next);
  assign bus.mem_raddr  = r_raddr;
  assign bus.mem_waddr  = r_waddr;
  assign bus.mem_wr     = r_wr;
  assign bus.eg_slot    = r_eg_slot;
  assign bus.eg_cur     = r_eg_cur;
  assign bus.eg_cur_vld = r_eg_vld;
  assign bus.host_ack   = r_ack;
  assign bus.frame_sync = w_fsync;
  assign bus.init_busy  = r_init_busy;
endmodule

// File: tb/tb_eg_slot_scheduler.sv
// Scoreboard bench: expected writes / eg_cur words queued per scenario and
// popped as the scheduler produces them; memory modelled in the bench.
module tb_eg_slot_scheduler;
  import vm2413::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  eg_slot_scheduler_if bus();
  eg_slot_scheduler dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed { SLOT_TYPE addr; EGDATA_TYPE data; } wr_t;

  EGDATA_TYPE mem [NSLOTS];
  wr_t        wq[$];
  wr_t        cq[$];
  logic       sb_on = 1'b0;
  int         n_pass = 0;
  int         n_chk = 0;
  int         n;

  // Synchronous-read memory, cleared while in reset (self-init).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOTS; i++) mem[i] <= '0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_rdata <= (bus.mem_raddr < SLOT_TYPE'(NSLOTS)) ? mem[bus.mem_raddr] : '0;
      if (bus.mem_wr && bus.mem_waddr < SLOT_TYPE'(NSLOTS))
        mem[bus.mem_waddr] <= bus.mem_wdata;
    end
  end

  assign bus.eg_next = EGDATA_TYPE'(bus.eg_slot) + 25'd1;

  // Clocks since reset release; run phase starts at 18.
  always @(posedge clk or posedge reset)
    if (reset) n <= 0; else n <= n + 1;

  function automatic int ex_stage(input int k); return (k - 18) % 4; endfunction
  function automatic int ex_slot(input int k); return ((k - 18) / 4) % 18; endfunction
  function automatic wr_t mk(input int a, input int d);
    return {SLOT_TYPE'(a), EGDATA_TYPE'(d)};
  endfunction

  always @(negedge clk) begin : mon
    wr_t e;
    if (sb_on && bus.mem_wr) begin
      n_chk++;
      if (wq.size() == 0)
        $display("FAIL sb_write: got (%0d,%h) expected none", bus.mem_waddr, bus.mem_wdata);
      else begin
        e = wq.pop_front();
        if ({bus.mem_waddr, bus.mem_wdata} !== e || ex_stage(n) < 2)
          $display("FAIL sb_write: got (%0d,%h) stage %0d expected (%0d,%h)",
                   bus.mem_waddr, bus.mem_wdata, ex_stage(n), e.addr, e.data);
        else n_pass++;
      end
    end
    if (sb_on && bus.eg_cur_vld) begin
      n_chk++;
      if (cq.size() == 0)
        $display("FAIL sb_egcur: got (%0d,%h) expected none", bus.eg_slot, bus.eg_cur);
      else begin
        e = cq.pop_front();
        if ({bus.eg_slot, bus.eg_cur} !== e || ex_stage(n) != 2)
          $display("FAIL sb_egcur: got (%0d,%h) stage %0d expected (%0d,%h)",
                   bus.eg_slot, bus.eg_cur, ex_stage(n), e.addr, e.data);
        else n_pass++;
      end
    end
  end

  task automatic wait_slot(input int s);
    int k = 0;
    @(negedge clk);
    while (!(n >= 18 && ex_stage(n) == 0 && ex_slot(n) == s) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_chk++;
      $display("FAIL wait_slot: slot %0d not reached, got n=%0d", s, n);
    end
  endtask

  task automatic sb_drain(input string name);
    sb_on = 1'b0;
    n_chk++;
    if (wq.size() != 0 || cq.size() != 0)
      $display("FAIL %s_drain: got %0d writes/%0d words left, expected 0/0", name, wq.size(), cq.size());
    else n_pass++;
    wq.delete();
    cq.delete();
  endtask

  task automatic test_reset;
    bus.host_req = 1'b0; bus.host_slot = '0; bus.host_data = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wr, bus.mem_wdata, bus.eg_slot, bus.eg_cur,
         bus.eg_cur_vld, bus.host_ack, bus.frame_sync} !== '0 || bus.init_busy !== 1'b1)
      $display("FAIL reset_vals: got wr=%b raddr=%0d busy=%b fs=%b expected all 0, busy=1",
               bus.mem_wr, bus.mem_raddr, bus.init_busy, bus.frame_sync);
    else n_pass++;
    // Request raised during init must be held off until the first host window.
    bus.host_req = 1'b1; bus.host_slot = 5'd3; bus.host_data = 25'h0AAAAA;
    reset = 1'b0;
    for (int k = 0; k < INIT_CYCLES; k++) begin
      n_chk++;
      if (bus.init_busy !== 1'b1 || bus.mem_wr !== 1'b0 || bus.host_ack !== 1'b0 || bus.eg_cur_vld !== 1'b0)
        $display("FAIL init_hold: clk %0d got busy=%b wr=%b ack=%b vld=%b expected 1,0,0,0",
                 k, bus.init_busy, bus.mem_wr, bus.host_ack, bus.eg_cur_vld);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (bus.init_busy !== 1'b0 || bus.mem_raddr !== 5'd0 || bus.frame_sync !== 1'b1)
      $display("FAIL first_stage0: got busy=%b raddr=%0d fs=%b expected 0,0,1",
               bus.init_busy, bus.mem_raddr, bus.frame_sync);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.frame_sync !== 1'b0) $display("FAIL fs_pulse: got %b expected 0", bus.frame_sync);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.mem_wr !== 1'b1 || bus.mem_waddr !== 5'd0 || bus.mem_wdata !== 25'd1)
      $display("FAIL first_egwr: got (%b,%0d,%h) expected (1,0,1)", bus.mem_wr, bus.mem_waddr, bus.mem_wdata);
    else n_pass++;
    @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b1 || bus.mem_wr !== 1'b1 || bus.mem_waddr !== 5'd3 || bus.mem_wdata !== 25'h0AAAAA)
      $display("FAIL init_host: got ack=%b (%b,%0d,%h) expected ack=1 (1,3,0aaaaa)",
               bus.host_ack, bus.mem_wr, bus.mem_waddr, bus.mem_wdata);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b0) $display("FAIL ack_once: got %b expected 0", bus.host_ack);
    else n_pass++;
  endtask

  task automatic test_free_run;
    int t_fs = -1;
    wait_slot(0);
    for (int s = 0; s < NSLOTS; s++) begin
      wq.push_back(mk(s, s + 1));
      cq.push_back(mk(s, s + 1));
    end
    wq.push_back(mk(0, 1));
    cq.push_back(mk(0, 1));
    sb_on = 1'b1;
    for (int k = 0; k < 76; k++) begin
      if (ex_stage(n) == 0) begin
        n_chk++;
        if (bus.mem_raddr !== SLOT_TYPE'(ex_slot(n)) || bus.frame_sync !== (ex_slot(n) == 0))
          $display("FAIL run_raddr: got raddr=%0d fs=%b expected %0d,%b",
                   bus.mem_raddr, bus.frame_sync, ex_slot(n), ex_slot(n) == 0);
        else n_pass++;
      end
      if (bus.frame_sync) begin
        if (t_fs >= 0) begin
          n_chk++;
          if (n - t_fs != 72) $display("FAIL fs_period: got %0d expected 72", n - t_fs);
          else n_pass++;
        end
        t_fs = n;
      end
      @(negedge clk);
    end
    sb_drain("free_run");
  endtask

  task automatic test_host_write;
    int acks = 0;
    wait_slot(2);
    bus.host_req = 1'b1; bus.host_slot = 5'd5; bus.host_data = 25'h1ABCDE;
    wq.push_back(mk(2, 3));
    wq.push_back(mk(5, 25'h1ABCDE));
    wq.push_back(mk(3, 4));
    wq.push_back(mk(4, 5));
    wq.push_back(mk(5, 6));
    cq.push_back(mk(2, 3));
    cq.push_back(mk(3, 4));
    cq.push_back(mk(4, 5));
    cq.push_back(mk(5, 25'h1ABCDE));
    sb_on = 1'b1;
    for (int k = 0; k < 16; k++) begin
      if (bus.host_ack) begin
        acks++;
        n_chk++;
        if (ex_stage(n) != 3 || ex_slot(n) != 2)
          $display("FAIL host_ack_pos: got slot %0d stage %0d expected slot 2 stage 3", ex_slot(n), ex_stage(n));
        else n_pass++;
        bus.host_req = 1'b0;
      end
      @(negedge clk);
    end
    n_chk++;
    if (acks != 1) $display("FAIL host_ack_cnt: got %0d expected 1", acks);
    else n_pass++;
    bus.host_req = 1'b0;
    sb_drain("host_write");
  endtask

  task automatic test_same_slot;
    wait_slot(7);
    @(negedge clk);
    wq.push_back(mk(7, 8));
    wq.push_back(mk(7, 25'h0F0F0F));
    cq.push_back(mk(7, 8));
    sb_on = 1'b1;
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_slot = 5'd7; bus.host_data = 25'h0F0F0F;
    @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b1) $display("FAIL hazard_ack: got %b expected 1", bus.host_ack);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (mem[7] !== 25'h0F0F0F) $display("FAIL hazard_mem: got %h expected 0f0f0f", mem[7]);
    else n_pass++;
    sb_drain("same_slot");
  endtask

  task automatic test_bad_slot;
    wait_slot(9);
    wq.push_back(mk(9, 10));
    cq.push_back(mk(9, 10));
    sb_on = 1'b1;
    bus.host_req = 1'b1; bus.host_slot = 5'd20; bus.host_data = 25'h1234567;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b1 || bus.mem_wr !== 1'b0)
      $display("FAIL bad_slot: got ack=%b wr=%b expected ack=1 wr=0", bus.host_ack, bus.mem_wr);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b0) $display("FAIL bad_slot_once: got %b expected 0", bus.host_ack);
    else n_pass++;
    sb_drain("bad_slot");
  endtask

  task automatic test_reset_mid;
    wait_slot(11);
    @(negedge clk);
    bus.host_req = 1'b1; bus.host_slot = 5'd4; bus.host_data = 25'h00C0FE;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_raddr, bus.mem_waddr, bus.mem_wr, bus.mem_wdata, bus.eg_slot, bus.eg_cur,
         bus.eg_cur_vld, bus.host_ack, bus.frame_sync} !== '0 || bus.init_busy !== 1'b1)
      $display("FAIL mid_reset_vals: got wr=%b raddr=%0d ack=%b busy=%b expected 0,0,0,1",
               bus.mem_wr, bus.mem_raddr, bus.host_ack, bus.init_busy);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < INIT_CYCLES; k++) begin
      n_chk++;
      if (bus.init_busy !== 1'b1 || bus.host_ack !== 1'b0 || bus.mem_wr !== 1'b0)
        $display("FAIL mid_init: clk %0d got busy=%b ack=%b wr=%b expected 1,0,0",
                 k, bus.init_busy, bus.host_ack, bus.mem_wr);
      else n_pass++;
      @(negedge clk);
    end
    n_chk++;
    if (bus.init_busy !== 1'b0 || bus.mem_raddr !== 5'd0 || bus.frame_sync !== 1'b1)
      $display("FAIL mid_restart: got busy=%b raddr=%0d fs=%b expected 0,0,1",
               bus.init_busy, bus.mem_raddr, bus.frame_sync);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_chk++;
    if (bus.host_ack !== 1'b1 || bus.mem_waddr !== 5'd4 || bus.mem_wdata !== 25'h00C0FE)
      $display("FAIL mid_represent: got ack=%b (%0d,%h) expected ack=1 (4,00c0fe)",
               bus.host_ack, bus.mem_waddr, bus.mem_wdata);
    else n_pass++;
    bus.host_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_free_run;
    test_host_write;
    test_same_slot;
    test_bad_slot;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
